dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the processor's load/store path and an external host port (loader/debug), with a valid/ready style handshake on the host side.
- Sits between the processor datapath (ALU result as address, register-file read-data 2 as write data, MemRead/MemWrite controls) and the data memory.
- Arbitrates every cycle, stalls the processor when it loses, and returns host read data registered, one cycle after grant.

Parameters:
- DATA_WIDTH, 32, width of write/read data on all ports.
- ADDR_WIDTH, 32, width of byte addresses on all ports.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- cpu_re  input  1  processor MemRead.
- cpu_we  input  1  processor MemWrite.
- cpu_addr  input  ADDR_WIDTH  processor ALU result.
- cpu_wdata  input  DATA_WIDTH  processor store data.
- cpu_rdata  output  DATA_WIDTH  load data to the write-back mux.
- cpu_stall  output  1  hold PC and suppress RegWrite this cycle.
- host_req  input  1  host access request.
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  ADDR_WIDTH  host address.
- host_wdata  input  DATA_WIDTH  host write data.
- host_gnt  output  1  host access performed this cycle.
- host_rdata  output  DATA_WIDTH  registered host read data.
- host_rvalid  output  1  host_rdata valid, one-cycle pulse.
- mem_re  output  1  to data memory MemRead.
- mem_we  output  1  to data memory MemWrite.
- mem_addr  output  ADDR_WIDTH  to data memory Address.
- mem_wdata  output  DATA_WIDTH  to data memory WriteData.
- mem_rdata  input  DATA_WIDTH  from data memory ReadData (combinational read).

Behaviour:
- Reset and polarity: clk is the only clock. Reset is synchronous and active-high: when reset is 1 at a rising edge of clk, all state is cleared.
  - FSM goes to PRI_CPU.
  - host_rvalid is 0 and host_rdata is 0.
  - Combinational outputs follow their equations. During reset, host_gnt and mem_we are forced to 0.
- cpu_act: cpu_act = cpu_re | cpu_we. If cpu_re and cpu_we are both asserted, the request is treated as a write: mem_re = 0.
- Priority FSM: two states, PRI_CPU and PRI_HOST.
  - Contention (cpu_act & host_req) in PRI_CPU: CPU wins, next state is PRI_HOST.
  - Contention in PRI_HOST: host wins, next state is PRI_CPU.
  - Only one requester active: that requester wins and the state is unchanged.
  - No requester active: nothing is granted and the state is unchanged.
- Stall bound: cpu_stall is asserted for at most 1 consecutive cycle. Host wait is also bounded to 1 cycle.
- Grant outputs are combinational in the same cycle:
  - mem_* are driven from the winner.
  - When idle, all mem_* are 0.
- CPU path:
  - cpu_rdata = mem_rdata when the CPU is granted, else 0.
  - cpu_stall = cpu_act & ~cpu_grant.
  - When cpu_stall is 1, the processor presents the same request next cycle.
- Host path:
  - host_gnt = host_req & host_grant.
  - The host holds host_req, host_we, host_addr and host_wdata stable until it sees host_gnt = 1 at a clock edge.
  - A host read granted in cycle N has mem_rdata captured at the edge ending N. host_rvalid = 1 and host_rdata are valid in cycle N+1.
  - host_rdata holds its value until the next host read grant.
  - Host writes never assert host_rvalid.
- Back-to-back host reads: rvalid pulses each cycle; no bubble is required.
- Reset mid-operation: a pending host_rvalid is dropped. A host read granted in the same cycle that reset is asserted does not produce rvalid.
- Addresses and data pass through unchanged; the arbiter performs no decoding.

Decomposition:
- Shared package, used by the processor top and the bench:
  - arb_state_t enum {PRI_CPU, PRI_HOST}.
  - Constants GRANT_NONE, GRANT_CPU, GRANT_HOST for the 2-bit grant code.
- One sub-module: dmem_arb_fsm. It takes cpu_act and host_req and returns the grant code and the state register.
- Muxing and the read-data register stay in dmem_arbiter.

Test Plan:
- Reset, then cpu_we = 1, cpu_addr = 0x10, cpu_wdata = 0xDEADBEEF, host idle -> mem_we = 1, mem_addr = 0x10 in the same cycle, cpu_stall = 0. A later cpu_re at 0x10 returns cpu_rdata = 0xDEADBEEF.
- Host-only read at 0x20 holding 0x12345678 -> host_gnt = 1 in cycle N; host_rvalid = 1 and host_rdata = 0x12345678 in N+1; rvalid = 0 in N+2.
- Contention from PRI_CPU: CPU read at 0x0 and host write at 0x4 both held -> cycle 1: CPU granted, host_gnt = 0, cpu_stall = 0. Cycle 2: host granted, and with cpu_re held, cpu_stall = 1.
- Continuous contention for 6 cycles -> grants alternate CPU, host, CPU, host, CPU, host; cpu_stall is never 1 for two consecutive cycles.
- Simultaneous cpu_re = cpu_we = 1 -> mem_we = 1 and mem_re = 0.
- Reset asserted in the cycle a host read is granted -> host_rvalid = 0 next cycle, FSM = PRI_CPU, host_rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: priority state and grant codes.
package dmem_arbiter_pkg;

    localparam int unsigned GRANT_W = 2;

    typedef logic [GRANT_W-1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'd0;
    localparam grant_t GRANT_CPU  = 2'd1;
    localparam grant_t GRANT_HOST = 2'd2;

    // Which requester wins the next contended cycle.
    typedef enum logic {
        PRI_CPU  = 1'b0,
        PRI_HOST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Alternating-priority arbiter core for the shared data memory.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   cpu_act    - processor load or store pending
//   host_req   - host access pending
//   grant_c    - combinational grant code for this cycle
//   state      - priority state register
module dmem_arb_fsm
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_act,
    input  logic       host_req,
    output grant_t     grant_c,
    output arb_state_t state
);

    arb_state_t state_next;

    // Priority state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRI_CPU;
        end else begin
            state <= state_next;
        end
    end

    // Grant decode; only contention moves the priority, to the loser.
    always_comb begin
        state_next = state;
        grant_c    = GRANT_NONE;
        if (cpu_act && host_req) begin
            if (state == PRI_CPU) begin
                grant_c    = GRANT_CPU;
                state_next = PRI_HOST;
            end else begin
                grant_c    = GRANT_HOST;
                state_next = PRI_CPU;
            end
        end else if (cpu_act) begin
            grant_c = GRANT_CPU;
        end else if (host_req) begin
            grant_c = GRANT_HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the processor load/store path
// and an external host port. Grants and memory controls are combinational;
// host read data is registered and returned one cycle after grant.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   cpu_re/we/addr/wdata - processor request; cpu_rdata, cpu_stall back
//   host_req/we/addr/wdata - host request; host_gnt, host_rdata, host_rvalid back
//   mem_re/we/addr/wdata - data memory controls; mem_rdata from memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic       cpu_act;
    logic       cpu_grant;
    logic       host_rd_gnt;
    grant_t     grant;
    arb_state_t state;

    assign cpu_act = cpu_re | cpu_we;

    dmem_arb_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .cpu_act  (cpu_act),
        .host_req (host_req),
        .grant_c  (grant),
        .state    (state)
    );

    assign cpu_grant   = (grant == GRANT_CPU);
    // Host accesses are suppressed while reset is held.
    assign host_gnt    = host_req & (grant == GRANT_HOST) & ~reset;
    assign host_rd_gnt = host_gnt & ~host_we;

    assign cpu_stall = cpu_act & ~cpu_grant;
    assign cpu_rdata = cpu_grant ? mem_rdata : '0;

    // Memory port mux; re+we together from the CPU is treated as a write.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_re    = cpu_re & ~cpu_we;
            mem_we    = cpu_we & ~reset;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_re    = ~host_we;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Host read data register; rdata holds until the next host read grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_rd_gnt;
            if (host_rd_gnt) begin
                host_rdata <= mem_rdata;
            end
        end
    end

    a_reset_prio: assert property (@(posedge clk) reset |=> (state == PRI_CPU));

endmodule
